// File: rtl/cpu_state_sequencer.sv
// Phase sequencer for the 4-bit-opcode CPU: one-hot FETCH/EXEC1/EXEC2 strobes with
// run/single-step control, fetch wait states with optional timeout, STP halt and a retire counter.
module cpu_state_sequencer #(
   parameter int CNT_W    = 16,
   parameter int FETCH_TO = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             step_req,
   input  logic             resume,
   input  logic             mem_ready,
   input  logic             extra,
   input  logic             stp,
   output logic             fetch,
   output logic             exec1,
   output logic             exec2,
   output logic             step_ack,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC1,
      S_EXEC2,
      S_HALT
   } state_t;

   localparam int TO_W = (FETCH_TO > 1) ? $clog2(FETCH_TO + 1) : 1;
   localparam logic [TO_W-1:0] TO_LAST = (FETCH_TO > 0) ? TO_W'(FETCH_TO - 1) : '0;

   state_t          state;
   state_t          next_state;
   logic            step_flag;
   logic [TO_W-1:0] wait_cnt;
   logic            retire;
   logic            count_inc;
   logic            timeout;

   // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      next_state = state;
      retire     = 1'b0;
      count_inc  = 1'b0;
      timeout    = 1'b0;
      case (state)
         S_IDLE: begin
            if (run || step_req) next_state = S_FETCH;
         end
         S_FETCH: begin
            if (mem_ready) begin
               next_state = S_EXEC1;
            end else if ((FETCH_TO > 0) && (wait_cnt == TO_LAST)) begin
               next_state = S_HALT;
               timeout    = 1'b1;
            end
         end
         S_EXEC1: begin
            if (stp) begin
               next_state = S_HALT;
               count_inc  = 1'b1;
            end else if (extra) begin
               next_state = S_EXEC2;
            end else begin
               retire = 1'b1;
            end
         end
         S_EXEC2: retire = 1'b1;
         S_HALT: begin
            if (resume) next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase

      // A single-stepped instruction always returns to IDLE, even if run has since risen.
      if (retire) begin
         count_inc = 1'b1;
         if (step_flag)  next_state = S_IDLE;
         else if (run)   next_state = S_FETCH;
         else            next_state = S_IDLE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_flag   <= 1'b0;
         step_ack    <= 1'b0;
         wait_cnt    <= '0;
         fault       <= 1'b0;
         instr_count <= '0;
      end else begin
         step_ack <= retire && step_flag;

         // run has priority over step_req when both are seen in IDLE.
         if ((state == S_IDLE) && (next_state == S_FETCH)) step_flag <= !run;
         else if (retire || (next_state == S_HALT))        step_flag <= 1'b0;

         if ((state == S_FETCH) && !mem_ready && !timeout) wait_cnt <= wait_cnt + 1'b1;
         else                                              wait_cnt <= '0;

         if (timeout)                            fault <= 1'b1;
         else if ((state == S_HALT) && resume)   fault <= 1'b0;

         if (count_inc) instr_count <= instr_count + 1'b1;
      end
   end

   assign fetch  = (state == S_FETCH);
   assign exec1  = (state == S_EXEC1);
   assign exec2  = (state == S_EXEC2);
   assign halted = (state == S_HALT);

endmodule

// File: tb/tb_cpu_state_sequencer.sv
// Self-checking bench for cpu_state_sequencer: directed vector table, hand-written corner
// sequences (reset mid-instruction, fetch timeout, counter wrap) and a random run against a model.
module tb_cpu_state_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   logic run, step_req, resume, mem_ready, extra, stp;
   logic fetch, exec1, exec2, step_ack, halted, fault;
   logic [15:0] instr_count;

   logic run2, step_req2, resume2, mem_ready2, extra2, stp2;
   logic to_fetch, to_exec1, to_exec2, to_ack, to_halted, to_fault;
   logic [3:0] to_count;

   logic [5:0] m_flags, to_flags;
   assign m_flags  = {fetch, exec1, exec2, step_ack, halted, fault};
   assign to_flags = {to_fetch, to_exec1, to_exec2, to_ack, to_halted, to_fault};

   always #5 clk = ~clk;

   cpu_state_sequencer #(.CNT_W(16), .FETCH_TO(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .run(run), .step_req(step_req), .resume(resume),
      .mem_ready(mem_ready), .extra(extra), .stp(stp), .fetch(fetch), .exec1(exec1),
      .exec2(exec2), .step_ack(step_ack), .halted(halted), .fault(fault),
      .instr_count(instr_count)
   );

   cpu_state_sequencer #(.CNT_W(4), .FETCH_TO(3)) u_to (
      .clk(clk), .rst_n(rst_n), .run(run2), .step_req(step_req2), .resume(resume2),
      .mem_ready(mem_ready2), .extra(extra2), .stp(stp2), .fetch(to_fetch), .exec1(to_exec1),
      .exec2(to_exec2), .step_ack(to_ack), .halted(to_halted), .fault(to_fault),
      .instr_count(to_count)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // inputs {run, step_req, resume, mem_ready, extra, stp};
   // flags  {fetch, exec1, exec2, step_ack, halted, fault}
   typedef struct {
      logic [5:0]  in;
      logic [5:0]  exp_flags;
      logic [15:0] exp_count;
   } vec_t;
   vec_t vecs[$];

   // Reference model: instruction progress, not sequencer states.
   int         m_mode;      // 0 idle, 1 inside an instruction, 2 halted
   bit         m_fetched;
   int         m_pos;       // execute cycle index once fetched
   bit         m_step, m_ack, m_fault;
   logic [15:0] m_count;

   function automatic logic [5:0] model_flags();
      return {m_mode == 1 && !m_fetched, m_mode == 1 && m_fetched && m_pos == 0,
              m_mode == 1 && m_fetched && m_pos == 1, m_ack, m_mode == 2, m_fault};
   endfunction

   task automatic model_step();
      bit finish = 1'b0;
      bit new_ack = 1'b0;
      case (m_mode)
         0: begin
            if (run)           begin m_mode = 1; m_fetched = 0; m_step = 0; end
            else if (step_req) begin m_mode = 1; m_fetched = 0; m_step = 1; end
         end
         1: begin
            if (!m_fetched) begin
               if (mem_ready) begin m_fetched = 1; m_pos = 0; end
            end else if (m_pos == 0) begin
               if (stp) begin m_count = m_count + 16'd1; m_mode = 2; m_step = 0; end
               else if (extra) m_pos = 1;
               else finish = 1'b1;
            end else begin
               finish = 1'b1;
            end
         end
         default: if (resume) begin m_mode = 0; m_fault = 0; end
      endcase
      if (finish) begin
         m_count = m_count + 16'd1;
         if (m_step)   begin new_ack = 1'b1; m_step = 0; m_mode = 0; end
         else if (run) m_fetched = 0;
         else          m_mode = 0;
      end
      m_ack = new_ack;
   endtask

   task automatic set_main(input logic [5:0] v);
      {run, step_req, resume, mem_ready, extra, stp} = v;
   endtask

   initial begin
      rst_n = 1'b0;
      set_main(6'b0);
      {run2, step_req2, resume2, mem_ready2, extra2, stp2} = 6'b0;

      // Directed table: continuous run, single step with EXEC2, STP halt, wait states, run+step.
      vecs.push_back('{6'b100100, 6'b100000, 16'd0});
      vecs.push_back('{6'b100100, 6'b010000, 16'd0});
      vecs.push_back('{6'b100100, 6'b100000, 16'd1});
      vecs.push_back('{6'b110100, 6'b010000, 16'd1});
      vecs.push_back('{6'b100100, 6'b100000, 16'd2});
      vecs.push_back('{6'b100100, 6'b010000, 16'd2});
      vecs.push_back('{6'b000100, 6'b000000, 16'd3});
      vecs.push_back('{6'b010010, 6'b100000, 16'd3});
      vecs.push_back('{6'b000110, 6'b010000, 16'd3});
      vecs.push_back('{6'b000110, 6'b001000, 16'd3});
      vecs.push_back('{6'b000000, 6'b000100, 16'd4});
      vecs.push_back('{6'b001000, 6'b000000, 16'd4});
      vecs.push_back('{6'b100100, 6'b100000, 16'd4});
      vecs.push_back('{6'b100100, 6'b010000, 16'd4});
      vecs.push_back('{6'b100101, 6'b000010, 16'd5});
      vecs.push_back('{6'b110100, 6'b000010, 16'd5});
      vecs.push_back('{6'b001000, 6'b000000, 16'd5});
      vecs.push_back('{6'b100000, 6'b100000, 16'd5});
      vecs.push_back('{6'b100000, 6'b100000, 16'd5});
      vecs.push_back('{6'b100000, 6'b100000, 16'd5});
      vecs.push_back('{6'b100000, 6'b100000, 16'd5});
      vecs.push_back('{6'b100000, 6'b100000, 16'd5});
      vecs.push_back('{6'b100100, 6'b010000, 16'd5});
      vecs.push_back('{6'b000100, 6'b000000, 16'd6});
      vecs.push_back('{6'b110100, 6'b100000, 16'd6});
      vecs.push_back('{6'b000100, 6'b010000, 16'd6});
      vecs.push_back('{6'b000100, 6'b000000, 16'd7});
      vecs.push_back('{6'b000000, 6'b000000, 16'd7});

      #12;
      check("reset main outputs", {26'd0, m_flags}, 32'd0);
      check("reset main count", {16'd0, instr_count}, 32'd0);
      check("reset to outputs", {22'd0, to_flags, to_count}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         set_main(vecs[i].in);
         tick();
         check($sformatf("vec%0d", i), {10'd0, m_flags, instr_count},
               {10'd0, vecs[i].exp_flags, vecs[i].exp_count});
      end

      // Reset asserted in the middle of an EXEC2 cycle.
      set_main(6'b010110);
      tick();
      set_main(6'b000110);
      tick();
      tick();
      check("pre-reset exec2", {26'd0, m_flags}, {26'd0, 6'b001000});
      #2 rst_n = 1'b0;
      #1;
      check("reset mid-exec2 outputs", {26'd0, m_flags}, 32'd0);
      check("reset mid-exec2 count", {16'd0, instr_count}, 32'd0);
      set_main(6'b0);
      #1 rst_n = 1'b1;
      tick();
      check("post-reset idle", {10'd0, m_flags, instr_count}, 32'd0);

      // Fetch timeout with FETCH_TO=3: three waiting FETCH cycles, then HALT with fault.
      run2 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("to fetch wait%0d", i), {26'd0, to_flags}, {26'd0, 6'b100000});
      end
      tick();
      check("to timeout halt", {22'd0, to_flags, to_count}, {22'd0, 6'b000011, 4'd0});
      tick();
      check("to halt ignores run", {26'd0, to_flags}, {26'd0, 6'b000011});
      resume2 = 1'b1;
      tick();
      resume2 = 1'b0;
      check("to resume clears", {26'd0, to_flags}, 32'd0);

      // Two waits then ready: one short of the timeout, the instruction completes.
      tick();
      tick();
      tick();
      mem_ready2 = 1'b1;
      tick();
      check("to ready at last wait", {26'd0, to_flags}, {26'd0, 6'b010000});
      run2 = 1'b0;
      tick();
      check("to retire count", {22'd0, to_flags, to_count}, {22'd0, 6'b000000, 4'd1});

      // 4-bit counter wrap: 14 more retirements reach F, the next one wraps to 0.
      run2 = 1'b1;
      repeat (29) tick();
      check("to count at max", {28'd0, to_count}, 32'hF);
      tick();
      run2 = 1'b0;
      tick();
      check("to count wrapped", {22'd0, to_flags, to_count}, 32'd0);
      mem_ready2 = 1'b0;

      // Random stimulus on the main instance against the reference model.
      m_mode = 0; m_fetched = 0; m_pos = 0; m_step = 0; m_ack = 0; m_fault = 0;
      m_count = 16'd0;
      for (int c = 0; c < 600; c++) begin
         check($sformatf("rand%0d", c), {10'd0, m_flags, instr_count},
               {10'd0, model_flags(), m_count});
         run       = ($urandom_range(0, 3) != 0);
         step_req  = ($urandom_range(0, 5) == 0);
         resume    = ($urandom_range(0, 3) == 0);
         mem_ready = ($urandom_range(0, 3) != 0);
         extra     = $urandom_range(0, 1) != 0;
         stp       = ($urandom_range(0, 9) == 0);
         model_step();
         tick();
      end
      check("rand final", {10'd0, m_flags, instr_count}, {10'd0, model_flags(), m_count});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
